// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data RAM port among NREQ requesters; one access at a time via IDLE/ACCESS/WAIT/DONE.
// Grant-to-ack is 1 cycle for writes, 1+RD_LAT for reads; other requesters simply hold req while busy is high.
module mem_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 5,
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    wr,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_data,
  output logic               ram_wren,
  input  logic [DW-1:0]      ram_q
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      r_state;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic            r_wr;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic [CW-1:0]   r_cnt;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_idx;
  logic [NREQ-1:0] w_win_oh;

  // Search begins one past the last winner so every pending requester gets a turn before a repeat.
  always_comb begin
    w_found  = 1'b0;
    w_win    = r_ptr;
    w_idx    = '0;
    w_win_oh = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_win_oh[w_win] = w_found;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ptr   <= PW'(NREQ - 1);
      r_gnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_win_oh;
            r_ptr   <= w_win;
            r_wr    <= wr[w_win];
            r_addr  <= addr[w_win*AW +: AW];
            r_wdata <= wdata[w_win*DW +: DW];
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_wr) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= CW'(RD_LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // ram_q is valid on the last counted cycle because the address has been stable since ACCESS.
          if (r_cnt == CW'(1)) begin
            r_rdata <= ram_q;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign ack      = (r_state == S_DONE) ? r_gnt : '0;
  assign busy     = (r_state != S_IDLE);
  assign rdata    = r_rdata;
  assign ram_addr = r_addr;
  assign ram_data = r_wdata;
  assign ram_wren = (r_state == S_ACCESS) && r_wr;

  a_gnt_onehot: assert property (@(posedge clock) disable iff (!resetn) $onehot0(r_gnt));
  a_wren_access: assert property (@(posedge clock) disable iff (!resetn) ram_wren |-> (r_state == S_ACCESS));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM model, per-cycle reference model compare, plus literal scenario checks.
module tb_mem_arbiter;
  localparam int NREQ   = 4;
  localparam int AW     = 5;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << AW;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    wr = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_data;
  logic               ram_wren;
  logic [DW-1:0]      ram_q;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .resetn(resetn), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [DW-1:0] ram_init(input int a);
    return DW'(32'h1000 + a);
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // RAM with RD_LAT-stage read pipeline
  logic          init_ram = 1'b1;
  logic [DW-1:0] ram  [0:DEPTH-1];
  logic [DW-1:0] pipe [0:RD_LAT-1];
  always @(posedge clock) begin
    if (init_ram) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= ram_init(i);
    end else if (ram_wren) begin
      ram[ram_addr] <= ram_data;
    end
    pipe[0] <= ram[ram_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[RD_LAT-1];

  // Reference model: an access is a run of cycles counted from the grant; reads last 1+RD_LAT, writes 1.
  logic [DW-1:0] mmem [0:DEPTH-1];
  bit            m_init = 1'b0;
  bit            m_active = 1'b0;
  int            m_age = 0, m_len = 0, m_who = 0, m_ptr = NREQ - 1;
  bit            m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;

  always @(negedge clock) begin : model
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_ack;
    int idx;
    cyc++;
    if (!m_init) begin
      for (int i = 0; i < DEPTH; i++) mmem[i] = ram_init(i);
      m_init = 1'b1;
    end
    if (!resetn) begin
      m_active = 1'b0; m_age = 0; m_ptr = NREQ - 1;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end
    e_gnt = m_active ? (NREQ'(1) << m_who) : '0;
    e_ack = (m_active && m_age == m_len) ? e_gnt : '0;
    chk($sformatf("c%0d gnt", cyc), 32'(gnt), 32'(e_gnt));
    chk($sformatf("c%0d ack", cyc), 32'(ack), 32'(e_ack));
    chk($sformatf("c%0d busy", cyc), 32'(busy), 32'(m_active));
    chk($sformatf("c%0d ram_wren", cyc), 32'(ram_wren), 32'(m_active && m_age == 0 && m_wr));
    chk($sformatf("c%0d ram_addr", cyc), 32'(ram_addr), 32'(m_addr));
    chk($sformatf("c%0d ram_data", cyc), 32'(ram_data), 32'(m_wdata));
    chk($sformatf("c%0d rdata", cyc), 32'(rdata), 32'(m_rdata));
    if (resetn) begin
      if (!m_active) begin
        if (req != '0) begin
          idx = -1;
          for (int k = 1; k <= NREQ; k++)
            if (idx < 0 && req[(m_ptr + k) % NREQ]) idx = (m_ptr + k) % NREQ;
          m_who = idx; m_ptr = idx; m_wr = wr[idx];
          m_addr = addr[idx*AW +: AW]; m_wdata = wdata[idx*DW +: DW];
          m_len = m_wr ? 1 : 1 + RD_LAT; m_age = 0; m_active = 1'b1;
        end
      end else begin
        if (m_age == 0 && m_wr) mmem[m_addr] = m_wdata;
        if (!m_wr && m_age == m_len - 1) m_rdata = mmem[m_addr];
        if (m_age == m_len) m_active = 1'b0;
        else m_age++;
      end
    end
  end

  initial begin : directed
    int order[$];
    int exp_order[5];
    int idle_run, last_ack, n;
    exp_order = '{0, 1, 2, 3, 0};

    step(3);
    init_ram = 1'b0;
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset rdata", 32'(rdata), 32'h0);
    chk("reset ram_addr", 32'(ram_addr), 32'h0);

    // single write by requester 0
    resetn = 1'b1; req = 4'b0001; wr = 4'b0001;
    addr[0 +: AW] = 5'd5; wdata[0 +: DW] = 16'h00AB;
    step(1);
    chk("wr gnt", 32'(gnt), 32'h1);
    chk("wr ram_wren", 32'(ram_wren), 32'h1);
    chk("wr ram_addr", 32'(ram_addr), 32'd5);
    chk("wr ram_data", 32'(ram_data), 32'h00AB);
    req = '0; wr = '0;
    step(1);
    chk("wr ack", 32'(ack), 32'h1);
    chk("wr wren drop", 32'(ram_wren), 32'h0);
    step(1);
    chk("wr idle busy", 32'(busy), 32'h0);

    // single read by requester 1
    req = 4'b0010; addr[AW +: AW] = 5'd5;
    step(1);
    chk("rd gnt", 32'(gnt), 32'h2);
    chk("rd wren", 32'(ram_wren), 32'h0);
    req = '0;
    step(2);
    chk("rd ack early", 32'(ack), 32'h0);
    step(1);
    chk("rd ack", 32'(ack), 32'h2);
    chk("rd rdata", 32'(rdata), 32'h00AB);
    step(1);

    // all four request continuously after reset
    resetn = 1'b0;
    step(2);
    resetn = 1'b1; req = 4'b1111; wr = 4'b0101;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW] = AW'(10 + i);
      wdata[i*DW +: DW] = DW'(32'h2000 + i);
    end
    idle_run = 0; last_ack = -1; n = 0;
    while (order.size() < 5 && n < 60) begin
      logic [NREQ-1:0] prev_gnt;
      prev_gnt = gnt;
      step(1);
      n++;
      if (gnt != '0 && prev_gnt == '0) begin
        if (order.size() > 0) begin
          chk("rr idle gap", 32'(idle_run), 32'd1);
          chk("rr ack before next", 32'(last_ack), 32'(order[order.size()-1]));
        end
        order.push_back(oh2i(gnt));
        if (order.size() == 5) req = '0;
      end
      if (ack != '0) begin last_ack = oh2i(ack); idle_run = 0; end
      if (!busy) idle_run++;
    end
    chk("rr grant count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < order.size()) chk($sformatf("rr order[%0d]", i), 32'(order[i]), 32'(exp_order[i]));
    n = 0;
    while (busy && n < 20) begin step(1); n++; end
    chk("rr drain", 32'(busy), 32'h0);

    // read by requester 1 withdrawn during WAIT
    req = 4'b0010; wr = '0; addr[AW +: AW] = 5'd12;
    step(1);
    chk("wd gnt", 32'(gnt), 32'h2);
    step(1);
    req = '0; addr = '0;
    step(1);
    chk("wd ack early", 32'(ack), 32'h0);
    step(1);
    chk("wd ack", 32'(ack), 32'h2);
    chk("wd rdata", 32'(rdata), 32'h2002);
    step(1);

    // reset during WAIT of requester 2 read
    req = 4'b0100; addr[2*AW +: AW] = 5'd3;
    step(1);
    chk("ra gnt", 32'(gnt), 32'h4);
    step(1);
    #1 resetn = 1'b0;
    #1;
    chk("ra gnt cleared", 32'(gnt), 32'h0);
    chk("ra ack none", 32'(ack), 32'h0);
    chk("ra busy", 32'(busy), 32'h0);
    chk("ra rdata", 32'(rdata), 32'h0);
    step(2);
    resetn = 1'b1;
    step(1);
    chk("ra regrant", 32'(gnt), 32'h4);
    req = '0;
    step(3);
    chk("ra ack", 32'(ack), 32'h4);
    chk("ra rdata after", 32'(rdata), 32'h1003);
    step(1);

    // write addr 7 by requester 3, then read it back by requester 0
    req = 4'b1000; wr = 4'b1000; addr[3*AW +: AW] = 5'd7; wdata[3*DW +: DW] = 16'hBEEF;
    step(1);
    chk("wb gnt", 32'(gnt), 32'h8);
    chk("wb ram_addr", 32'(ram_addr), 32'd7);
    chk("wb ram_data", 32'(ram_data), 32'hBEEF);
    req = '0; wr = '0;
    step(1);
    chk("wb ack", 32'(ack), 32'h8);
    chk("wb rdata kept", 32'(rdata), 32'h1003);
    step(1);
    req = 4'b0001; addr[0 +: AW] = 5'd7;
    step(1);
    chk("rb gnt", 32'(gnt), 32'h1);
    req = '0;
    step(3);
    chk("rb ack", 32'(ack), 32'h1);
    chk("rb rdata", 32'(rdata), 32'hBEEF);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the data RAM port.
REQ-002 Parameter AW, default 5: RAM word-address width.
REQ-003 Parameter DW, default 16: data word width.
REQ-004 Parameter RD_LAT, default 2, legal range 1..3: RAM clock cycles from address applied to ram_q valid.
REQ-005 The block SHALL have these ports:
- clock  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester access request, level.
- wr  in  NREQ  per-requester write enable (1 = write, 0 = read).
- addr  in  NREQ*AW  per-requester address; requester i uses slice [i*AW +: AW].
- wdata  in  NREQ*DW  per-requester write data; requester i uses slice [i*DW +: DW].
- gnt  out  NREQ  one-hot grant.
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- rdata  out  DW  read data, registered.
- busy  out  1  access in progress.
- ram_addr  out  AW  RAM address.
- ram_data  out  DW  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DW  RAM read data.

Function
REQ-006 The block SHALL implement an FSM with exactly four states, IDLE, ACCESS, WAIT and DONE; busy SHALL be 1 in every state except IDLE.
REQ-007 In IDLE with req == 0, the block SHALL remain in IDLE with gnt == 0.
REQ-008 In IDLE with any req bit set, the block SHALL select a winner round-robin:
- Search starts at index ptr+1 mod NREQ, where ptr is the last granted index.
- It registers the one-hot gnt and latches the winner's wr, addr and wdata.
- It sets ptr to the winner and moves to ACCESS.
REQ-009 ACCESS SHALL last one cycle:
- ram_addr and ram_data are driven from the latched values.
- ram_wren equals the latched wr.
- The next state is DONE for a write and WAIT for a read.
REQ-010 WAIT SHALL last exactly RD_LAT cycles, counted by a down-counter loaded on entry; ram_wren is 0 in WAIT.
REQ-011 On the last WAIT cycle, the block SHALL capture ram_q into rdata and then move to DONE.
REQ-012 DONE SHALL last one cycle:
- ack equals gnt for that cycle.
- The next state is IDLE, where gnt clears.
REQ-013 Grant-to-ack latency SHALL be 1 cycle for writes and 1+RD_LAT cycles for reads, with no back-to-back grants: every access passes through IDLE.
REQ-014 ram_addr SHALL hold its value from ACCESS through DONE and SHALL stay unchanged in IDLE.
REQ-015 ram_wren SHALL be 1 only in the ACCESS cycle of a write.
REQ-016 rdata SHALL change only on a read capture and SHALL keep its value across writes.
REQ-017 Requests and inputs that change after the grant cycle SHALL NOT affect the current access; a req withdrawn mid-access SHALL still complete, with ack issued.
REQ-018 A requester holding req after its ack SHALL be re-arbitrated in IDLE; round-robin guarantees every other pending requester is granted before it repeats.
REQ-019 Simultaneous requests SHALL be resolved only by the rotating pointer; no requester has fixed priority after the first grant.

Reset
REQ-020 While resetn == 0 (asserted asynchronously), the block SHALL hold:
- state = IDLE, ptr = NREQ-1 (so requester 0 wins first).
- gnt = 0, ack = 0, rdata = 0, busy = 0.
- ram_addr = 0, ram_data = 0, ram_wren = 0, WAIT counter = 0.
REQ-021 Reset asserted mid-access SHALL abort the access with no ack and ram_wren forced to 0 immediately; after release, arbitration restarts from requester 0.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single write: req=0001, wr=0001, addr0=5, wdata0=0x00AB -> gnt=0001; ram_wren=1 for 1 cycle with ram_addr=5 and ram_data=0x00AB; ack=0001 1 cycle after grant.
- Single read, RD_LAT=2: req=0010, addr1=5, RAM returns 0x00AB -> ram_wren stays 0; ack=0010 3 cycles after grant; rdata=0x00AB.
- All four request continuously after reset -> grant order 0,1,2,3,0; each grant followed by ack before the next; busy drops for exactly one IDLE cycle between accesses.
- req1 withdrawn during WAIT of a read -> access completes; ack=0010 issued; rdata updated.
- resetn pulled low during WAIT of a read by requester 2 -> outputs reset immediately with no ack; after release with req=0100, requester 2 is granted next.
- Write to addr 7 by requester 3, then read of addr 7 by requester 0 (RAM model) -> rdata equals the written value; rdata unchanged by the write itself.
